// File: rtl/contrast_cfg_sequencer_pkg.sv
// Shared types and constants for the contrast/brightness configuration sequencer.
// PDATA and color_t match the contrast_LUT parameter bus and the pixel component width.
package contrast_cfg_sequencer_pkg;

    localparam int PDATA = 16;

    typedef logic [7:0] color_t;

    typedef enum logic [1:0] {
        CFG_CONTRAST = 2'd0,
        CFG_BRIGHT   = 2'd1,
        CFG_COMMIT   = 2'd2,
        CFG_CLR_ERR  = 2'd3
    } cfg_addr_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_VB = 3'd1,
        APPLY_C = 3'd2,
        APPLY_B = 3'd3,
        DONE    = 3'd4
    } seq_state_t;

    localparam color_t CONTRAST_UNITY = 8'h08;

endpackage

// File: rtl/contrast_cfg_sequencer.sv
// Shadows host writes to contrast/brightness and commits them to the pipe during vblank,
// with an optional forced apply after TIMEOUT_CYC cycles and a sticky illegal-contrast flag.
module contrast_cfg_sequencer
    import contrast_cfg_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 11
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             host_valid,
    output logic             host_ready,
    input  logic [1:0]       host_addr,
    input  logic [PDATA-1:0] host_data,
    input  logic             vblank,
    output logic             cp_write_en,
    output logic [PDATA-1:0] cp_pdata,
    input  logic             lut_invalid,
    output logic             br_write_en,
    output color_t           br_value,
    output logic             busy,
    output logic             err_sticky,
    output color_t           err_code,
    output logic             commit_done
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    seq_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    color_t           contrast_reg, brightness_reg;
    logic             busy_reg, err_reg;
    color_t           err_code_reg;

    cfg_addr_t host_cmd;
    logic      host_fire;
    logic      unused_host_hi;

    assign host_cmd       = cfg_addr_t'(host_addr);
    assign host_ready     = (state_reg == IDLE) || (state_reg == WAIT_VB);
    assign host_fire      = host_valid && host_ready;
    assign unused_host_hi = ^host_data[PDATA-1:8];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (host_fire && host_cmd == CFG_COMMIT) begin
                    state_next = WAIT_VB;
                    cnt_next   = '0;
                end
            end
            WAIT_VB: begin
                // A second commit here is simply absorbed by staying in WAIT_VB.
                if (vblank) begin
                    state_next = APPLY_C;
                end else if (TIMEOUT_CYC != 0 && cnt_reg == TMO_LAST) begin
                    state_next = APPLY_C;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            APPLY_C: state_next = APPLY_B;
            APPLY_B: state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            contrast_reg   <= CONTRAST_UNITY;
            brightness_reg <= '0;
            busy_reg       <= 1'b0;
            err_reg        <= 1'b0;
            err_code_reg   <= '0;
        end else begin
            if (host_fire && host_cmd == CFG_CONTRAST) contrast_reg   <= host_data[7:0];
            if (host_fire && host_cmd == CFG_BRIGHT)   brightness_reg <= host_data[7:0];

            if (state_reg == IDLE && state_next == WAIT_VB) busy_reg <= 1'b1;
            else if (state_reg == DONE)                     busy_reg <= 1'b0;

            // Setting from APPLY_C outranks a clear; host_ready is low then anyway.
            if (state_reg == APPLY_C && lut_invalid) begin
                err_reg      <= 1'b1;
                err_code_reg <= contrast_reg;
            end else if (host_fire && host_cmd == CFG_CLR_ERR) begin
                err_reg      <= 1'b0;
                err_code_reg <= '0;
            end
        end
    end

    // Datapath values are presented only across the apply window so idle outputs read as zero.
    assign cp_write_en = (state_reg == APPLY_C);
    assign br_write_en = (state_reg == APPLY_B);
    assign commit_done = (state_reg == DONE);
    assign cp_pdata    = (state_reg == APPLY_C || state_reg == APPLY_B) ? PDATA'(contrast_reg) : '0;
    assign br_value    = (state_reg == APPLY_C || state_reg == APPLY_B) ? brightness_reg : '0;
    assign busy        = busy_reg;
    assign err_sticky  = err_reg;
    assign err_code    = err_code_reg;

endmodule

// File: tb/tb_contrast_cfg_sequencer.sv
// Directed bench: table of vblank commits plus hand sequences for waiting, clear, timeout and reset abort.
module tb_contrast_cfg_sequencer;
    import contrast_cfg_sequencer_pkg::*;

    logic             clk = 1'b0;
    logic             resetN;
    logic             host_valid;
    logic             host_ready;
    logic [1:0]       host_addr;
    logic [PDATA-1:0] host_data;
    logic             vblank;
    logic             cp_write_en;
    logic [PDATA-1:0] cp_pdata;
    logic             lut_invalid;
    logic             br_write_en;
    color_t           br_value;
    logic             busy;
    logic             err_sticky;
    color_t           err_code;
    logic             commit_done;

    // Second instance with a short timeout, driven only by the timeout sequence.
    logic             hv_t;
    logic             hr_t;
    logic [1:0]       ha_t;
    logic [PDATA-1:0] hd_t;
    logic             vb_t;
    logic             cpw_t;
    logic [PDATA-1:0] cpd_t;
    logic             brw_t;
    color_t           brv_t;
    logic             busy_t;
    logic             err_t;
    color_t           errc_t;
    logic             done_t;

    always #5 clk = ~clk;

    contrast_cfg_sequencer dut (
        .clk(clk), .resetN(resetN),
        .host_valid(host_valid), .host_ready(host_ready),
        .host_addr(host_addr), .host_data(host_data),
        .vblank(vblank),
        .cp_write_en(cp_write_en), .cp_pdata(cp_pdata), .lut_invalid(lut_invalid),
        .br_write_en(br_write_en), .br_value(br_value),
        .busy(busy), .err_sticky(err_sticky), .err_code(err_code),
        .commit_done(commit_done)
    );

    contrast_cfg_sequencer #(.TIMEOUT_CYC(16), .CNT_W(11)) dut_t (
        .clk(clk), .resetN(resetN),
        .host_valid(hv_t), .host_ready(hr_t),
        .host_addr(ha_t), .host_data(hd_t),
        .vblank(vb_t),
        .cp_write_en(cpw_t), .cp_pdata(cpd_t), .lut_invalid(1'b0),
        .br_write_en(brw_t), .br_value(brv_t),
        .busy(busy_t), .err_sticky(err_t), .err_code(errc_t),
        .commit_done(done_t)
    );

    // LUT model: codes that are not multiples of 8 are illegal; illegal writes are ignored.
    logic [7:0] lut_q = 8'h08;
    assign lut_invalid = (cp_pdata[2:0] != 3'b000);
    always @(posedge clk) if (cp_write_en && !lut_invalid) lut_q <= cp_pdata[7:0];

    int cp_cnt = 0;
    always @(posedge clk) if (cp_write_en) cp_cnt++;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else begin
            n_pass++;
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [1:0] a, input logic [7:0] d);
        int n;
        n = 0;
        while (!host_ready && n < 100) begin
            tick();
            n++;
        end
        if (!host_ready) chk("host_ready_timeout", 32'(host_ready), 32'd1);
        host_valid = 1'b1;
        host_addr  = a;
        host_data  = PDATA'(d);
        tick();
        host_valid = 1'b0;
        $display("write addr=%0d data=%02h", a, d);
    endtask

    // Runs the three apply cycles after a commit seen with vblank already high.
    task automatic check_apply(input string tag, input logic [7:0] c, input logic [7:0] b,
                               input logic e, input logic [7:0] ec, input logic [7:0] lut);
        tick();
        chk({tag, "_cp_we"}, 32'(cp_write_en), 32'd1);
        chk({tag, "_cp_pdata"}, 32'(cp_pdata), 32'(c));
        tick();
        chk({tag, "_br_we"}, 32'(br_write_en), 32'd1);
        chk({tag, "_br_value"}, 32'(br_value), 32'(b));
        chk({tag, "_err"}, 32'(err_sticky), 32'(e));
        chk({tag, "_err_code"}, 32'(err_code), 32'(ec));
        tick();
        chk({tag, "_done"}, 32'(commit_done), 32'd1);
        tick();
        chk({tag, "_busy_clr"}, 32'(busy), 32'd0);
        chk({tag, "_lut"}, 32'(lut_q), 32'(lut));
    endtask

    typedef struct {
        logic [7:0] contrast;
        logic [7:0] bright;
        logic       exp_err;
        logic [7:0] exp_code;
        logic [7:0] exp_lut;
    } vec_t;

    vec_t vecs[3];

    initial begin
        int n;
        int cp_before;

        vecs[0] = '{contrast: 8'h08, bright: 8'h00, exp_err: 1'b0, exp_code: 8'h00, exp_lut: 8'h08};
        vecs[1] = '{contrast: 8'h0B, bright: 8'h11, exp_err: 1'b1, exp_code: 8'h0B, exp_lut: 8'h08};
        vecs[2] = '{contrast: 8'h18, bright: 8'h22, exp_err: 1'b1, exp_code: 8'h0B, exp_lut: 8'h18};

        resetN = 1'b0; host_valid = 1'b0; host_addr = '0; host_data = '0; vblank = 1'b0;
        hv_t = 1'b0; ha_t = '0; hd_t = '0; vb_t = 1'b0;
        tick(); tick();
        resetN = 1'b1;
        tick();

        chk("rst_cp_we", 32'(cp_write_en), 32'd0);
        chk("rst_br_we", 32'(br_write_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_sticky), 32'd0);
        chk("rst_done", 32'(commit_done), 32'd0);
        chk("rst_pdata", 32'(cp_pdata), 32'd0);
        chk("rst_ready", 32'(host_ready), 32'd1);

        // Reset shadows commit straight away: unity contrast, zero brightness.
        vblank = 1'b1;
        host_write(2'd2, 8'h00);
        chk("commit_busy", 32'(busy), 32'd1);
        check_apply("rstcommit", 8'h08, 8'h00, 1'b0, 8'h00, 8'h08);

        for (int i = 0; i < 3; i++) begin
            host_write(2'd0, vecs[i].contrast);
            host_write(2'd1, vecs[i].bright);
            host_write(2'd2, 8'h00);
            check_apply($sformatf("vec%0d", i), vecs[i].contrast, vecs[i].bright,
                        vecs[i].exp_err, vecs[i].exp_code, vecs[i].exp_lut);
        end

        // Commit held off for 50 cycles of active video.
        vblank = 1'b0;
        host_write(2'd0, 8'h10);
        host_write(2'd1, 8'h20);
        host_write(2'd2, 8'h00);
        cp_before = cp_cnt;
        repeat (50) tick();
        chk("wait_no_strobe", 32'(cp_cnt), 32'(cp_before));
        chk("wait_busy", 32'(busy), 32'd1);
        chk("wait_ready", 32'(host_ready), 32'd1);
        vblank = 1'b1;
        check_apply("vbwait", 8'h10, 8'h20, 1'b1, 8'h0B, 8'h10);

        host_write(2'd3, 8'h00);
        chk("clr_err", 32'(err_sticky), 32'd0);
        chk("clr_code", 32'(err_code), 32'd0);
        host_write(2'd0, 8'h30);
        host_write(2'd2, 8'h00);
        check_apply("after_clr", 8'h30, 8'h20, 1'b0, 8'h00, 8'h30);

        // Forced apply on the short-timeout instance.
        hv_t = 1'b1; ha_t = 2'd2;
        tick();
        hv_t = 1'b0;
        n = 0;
        while (!cpw_t && n < 40) begin
            tick();
            n++;
        end
        chk("timeout_latency", 32'(n), 32'd16);
        tick(); tick(); tick();
        chk("timeout_idle", 32'(busy_t), 32'd0);

        // Reset in the middle of WAIT_VB abandons the commit and restores the shadows.
        vblank = 1'b0;
        host_write(2'd0, 8'h18);
        host_write(2'd2, 8'h00);
        tick(); tick();
        #2 resetN = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_cp_we", 32'(cp_write_en), 32'd0);
        chk("abort_pdata", 32'(cp_pdata), 32'd0);
        vblank = 1'b1;
        tick();
        resetN = 1'b1;
        cp_before = cp_cnt;
        repeat (5) tick();
        chk("abort_no_strobe", 32'(cp_cnt), 32'(cp_before));
        host_write(2'd2, 8'h00);
        check_apply("abort_recommit", 8'h08, 8'h00, 1'b0, 8'h00, 8'h08);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
